// File: rtl/pair_scan_controller_pkg.sv
// Shared encodings and detector transition helpers for the pair scan controller.
package pair_scan_controller_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Detector states: S0 no pending bit, L1 last bit was 1, L0 last bit was 0.
  typedef enum logic [1:0] {
    DET_S0 = 2'b00,
    DET_L1 = 2'b01,
    DET_L0 = 2'b10
  } det_state_e;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'b00,
    CTL_SCAN  = 2'b01,
    CTL_FLUSH = 2'b10,
    CTL_DONE  = 2'b11
  } ctl_state_e;

  // Next detector state for one strobed bit. A completed pair returns to S0,
  // which is what keeps matches from overlapping.
  function automatic det_state_e det_next(input det_state_e cur, input logic b);
    det_state_e nxt;
    case (cur)
      DET_S0:  nxt = b ? DET_L1 : DET_L0;
      DET_L1:  nxt = b ? DET_S0 : DET_L0;
      DET_L0:  nxt = b ? DET_L1 : DET_S0;
      default: nxt = DET_S0;
    endcase
    return nxt;
  endfunction

  // Mealy output: the strobed bit completes a 00 or 11 pair.
  function automatic logic det_match(input det_state_e cur, input logic b);
    logic m;
    case (cur)
      DET_L1:  m = b;
      DET_L0:  m = ~b;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pair_scan_controller_pair_detector.sv
// Bit-serial 00/11 pair detector with a registered match output.
//
// state | meaning
// S0    | no pending bit (start, or a pair just completed)
// L1    | last strobed bit was 1, waiting for its partner
// L0    | last strobed bit was 0, waiting for its partner
module pair_detector
  import pair_scan_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic in,
  output logic match
);

  det_state_e state_q, state_d;
  logic       match_q, match_d;

  // State and match registers; clear has the same effect as reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DET_S0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // Next state: advance only on strobed bits.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = DET_S0;
    end else if (en) begin
      state_d = det_next(state_q, in);
    end
  end

  // Match is only raised for a strobed bit, so it drops after any idle cycle.
  always_comb begin
    match_d = 1'b0;
    if (!clear && en) begin
      match_d = det_match(state_q, in);
    end
  end

  assign match = match_q;

endmodule

// File: rtl/pair_scan_controller.sv
// Word-to-bit-serial sequencer around pair_detector: accepts a word, shifts it
// LSB-first into the detector, counts matches and returns the count.
//
// state | meaning
// IDLE  | ready for a word
// SCAN  | one bit strobed into the detector per cycle
// FLUSH | no strobe; the last bit's match lands and is counted
// DONE  | count final, held until the consumer takes it
module pair_scan_controller
  import pair_scan_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             match_pulse,
  output logic [CNT_W-1:0] det_count,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int             IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ctl_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept;
  logic scan_abort;
  logic det_clear;
  logic det_hit;

  assign accept     = load_valid & load_ready;
  assign scan_abort = abort & ((state_q == CTL_SCAN) | (state_q == CTL_FLUSH));
  // Clearing on abort as well as accept guarantees the next word starts in S0.
  assign det_clear  = accept | scan_abort;

  // Controller state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CTL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTL_IDLE: begin
        if (accept) state_d = CTL_SCAN;
      end
      CTL_SCAN: begin
        if (abort)                 state_d = CTL_IDLE;
        else if (idx_q == LAST_IDX) state_d = CTL_FLUSH;
      end
      CTL_FLUSH: begin
        state_d = abort ? CTL_IDLE : CTL_DONE;
      end
      CTL_DONE: begin
        if (done_ready) state_d = CTL_IDLE;
      end
      default: state_d = CTL_IDLE;
    endcase
  end

  // Controller outputs decoded from the current state.
  always_comb begin
    load_ready = 1'b0;
    bit_strobe = 1'b0;
    bit_out    = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      CTL_IDLE: load_ready = 1'b1;
      CTL_SCAN: begin
        bit_strobe = 1'b1;
        bit_out    = shift_q[0];
      end
      CTL_DONE: done_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: shift register, bit index, match count.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Datapath next values; the count keeps its value through DONE and IDLE
  // until the next word is accepted.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    count_d = count_q;
    if (accept) begin
      shift_d = load_data;
      idx_d   = '0;
      count_d = '0;
    end else if (scan_abort) begin
      idx_d   = '0;
      count_d = '0;
    end else begin
      if (state_q == CTL_SCAN) begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        idx_d   = idx_q + IDX_W'(1);
      end
      if (((state_q == CTL_SCAN) || (state_q == CTL_FLUSH)) && det_hit) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  pair_detector u_det (
    .clock (clock),
    .reset (reset),
    .clear (det_clear),
    .en    (bit_strobe),
    .in    (bit_out),
    .match (det_hit)
  );

  assign match_pulse = det_hit;
  assign det_count   = count_q;

endmodule

// File: tb/tb_pair_scan_controller.sv
module tb_pair_scan_controller;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             abort;
  logic             bit_out;
  logic             bit_strobe;
  logic             match_pulse;
  logic [CNT_W-1:0] det_count;
  logic             done_valid;
  logic             done_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pair_scan_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .abort       (abort),
    .bit_out     (bit_out),
    .bit_strobe  (bit_strobe),
    .match_pulse (match_pulse),
    .det_count   (det_count),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: walk the bits LSB-first keeping at most one unpaired bit; a bit
  // equal to the unpaired one closes a pair and leaves nothing pending.
  function automatic logic [WIDTH-1:0] model_matches(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] m;
    int pending;
    m = '0;
    pending = -1;
    for (int k = 0; k < WIDTH; k++) begin
      if (pending == int'(w[k])) begin
        m[k] = 1'b1;
        pending = -1;
      end else begin
        pending = int'(w[k]);
      end
    end
    return m;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load_ready"},  {31'd0, load_ready},  32'd1);
    chk({tag, "_bit_out"},     {31'd0, bit_out},     32'd0);
    chk({tag, "_bit_strobe"},  {31'd0, bit_strobe},  32'd0);
    chk({tag, "_match_pulse"}, {31'd0, match_pulse}, 32'd0);
    chk({tag, "_det_count"},   32'(det_count),       32'd0);
    chk({tag, "_done_valid"},  {31'd0, done_valid},  32'd0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (load_ready !== 1'b1 && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    chk("wait_load_ready", {31'd0, load_ready}, 32'd1);
  endtask

  // Full cycle-exact transaction: accept, WIDTH strobed bits, flush, DONE held
  // for hold+1 cycles, then the return to IDLE.
  task automatic run_word(input logic [WIDTH-1:0] w, input int exp_cnt, input int hold,
                          input bit keep_valid, input bit abort_done, output int t_acc);
    logic [WIDTH-1:0] m;
    int running;
    m = model_matches(w);
    running = 0;
    wait_ready();
    load_valid = 1'b1;
    load_data  = w;
    t_acc      = cyc;
    @(negedge clock);
    if (!keep_valid) load_valid = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      chk("scan_strobe",     {31'd0, bit_strobe},  32'd1);
      chk("scan_bit_out",    {31'd0, bit_out},     {31'd0, w[k]});
      chk("scan_match",      {31'd0, match_pulse}, (k == 0) ? 32'd0 : {31'd0, m[k-1]});
      chk("scan_count",      32'(det_count),       32'(running));
      chk("scan_load_ready", {31'd0, load_ready},  32'd0);
      if (k > 0 && m[k-1]) running++;
      @(negedge clock);
    end
    chk("flush_strobe",     {31'd0, bit_strobe},  32'd0);
    chk("flush_match",      {31'd0, match_pulse}, {31'd0, m[WIDTH-1]});
    chk("flush_done_valid", {31'd0, done_valid},  32'd0);
    @(negedge clock);
    chk("done_match_low", {31'd0, match_pulse}, 32'd0);
    for (int h = 0; h <= hold; h++) begin
      chk("done_valid",      {31'd0, done_valid}, 32'd1);
      chk("done_count",      32'(det_count),      32'(exp_cnt));
      chk("done_load_ready", {31'd0, load_ready}, 32'd0);
      abort      = abort_done && (h == 0);
      done_ready = (h == hold);
      @(negedge clock);
    end
    abort      = 1'b0;
    done_ready = 1'b0;
    chk("idle_after_done_valid", {31'd0, done_valid}, 32'd0);
    chk("idle_after_load_ready", {31'd0, load_ready}, 32'd1);
    chk("idle_after_count",      32'(det_count),      32'(exp_cnt));
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    int               exp_count;
    int               hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t_acc;
    int t_prev;
    logic [WIDTH-1:0] w;

    vecs[0] = '{16'b0101011101110010, 3, 0};
    vecs[1] = '{16'hFFFF, 8, 0};
    vecs[2] = '{16'h0000, 8, 1};
    vecs[3] = '{16'hAAAA, 0, 0};
    vecs[4] = '{16'h5555, 0, 2};
    vecs[5] = '{16'h000F, 8, 0};
    vecs[6] = '{16'h8001, 7, 0};
    vecs[7] = '{16'hFFFF, 8, 5};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    abort      = 1'b0;
    done_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("post_reset");

    // Directed table, including the 5-cycle DONE hold on the last entry.
    foreach (vecs[i]) begin
      run_word(vecs[i].word, vecs[i].exp_count, vecs[i].hold, 1'b0, 1'b0, t_acc);
    end

    // abort while IDLE is ignored: count of the previous word survives.
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("idle_abort_ready", {31'd0, load_ready}, 32'd1);
    chk("idle_abort_count", 32'(det_count),      32'd8);

    // abort while DONE is ignored.
    run_word(16'h0F0F, 8, 2, 1'b0, 1'b1, t_acc);

    // abort in SCAN at T+6.
    wait_ready();
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    @(negedge clock);
    load_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_abort_count", 32'(det_count), 32'd1);
    @(negedge clock);
    chk("pre_abort_count2", 32'(det_count), 32'd2);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk_reset_vals("after_abort");
    @(negedge clock);
    chk("after_abort_no_done", {31'd0, done_valid}, 32'd0);
    run_word(16'hFFFF, 8, 0, 1'b0, 1'b0, t_acc);

    // reset at T+10 with abort also high: reset wins, word discarded.
    wait_ready();
    load_valid = 1'b1;
    load_data  = 16'h3333;
    @(negedge clock);
    load_valid = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre_reset_strobe", {31'd0, bit_strobe}, 32'd1);
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    abort = 1'b0;
    chk_reset_vals("mid_reset");
    @(negedge clock);
    chk_reset_vals("mid_reset_next");
    run_word(16'b0101011101110010, 3, 0, 1'b0, 1'b0, t_acc);

    // Back-to-back with load_valid held high throughout.
    t_prev = -1;
    for (int i = 0; i < 4; i++) begin
      w = 16'(($urandom() & 32'hFFFF));
      run_word(w, $countones(model_matches(w)), 0, 1'b1, 1'b0, t_acc);
      if (t_prev >= 0) begin
        chk("b2b_period_max", {31'd0, (t_acc - t_prev) <= WIDTH + 4}, 32'd1);
        chk("b2b_period_min", {31'd0, (t_acc - t_prev) >= WIDTH + 3}, 32'd1);
      end
      t_prev = t_acc;
    end
    load_valid = 1'b0;

    // Randomized words against the reference model.
    for (int i = 0; i < 24; i++) begin
      w = 16'(($urandom() & 32'hFFFF));
      run_word(w, $countones(model_matches(w)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b0, t_acc);
      load_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
